// File: rtl/mastermind_core_param.sv
// Parametrised Mastermind engine: guess editing, cycle-serial exact/partial scoring, win/loss tracking.
// Define MM_HISTORY_EN to add per-attempt history storage with a combinational read port.

module mastermind_peg_lane #(
    parameter int COLOR_W = 3
) (
    input  logic [COLOR_W-1:0] guess,
    input  logic [COLOR_W-1:0] target,
    input  logic [COLOR_W-1:0] colour,
    output logic               exact,
    output logic               g_hit,
    output logic               t_hit,
    output logic               filled
);
    assign exact  = (guess == target);
    assign g_hit  = (guess == colour);
    assign t_hit  = (target == colour);
    assign filled = (guess != '0);
endmodule

module mastermind_core_param #(
    parameter  int NUM_PEGS    = 4,
    parameter  int COLOR_W     = 3,
    parameter  int MAX_GUESSES = 6,
    localparam int IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1,
    localparam int GN_W  = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1,
    localparam int CNT_W = $clog2(NUM_PEGS + 1)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_PEGS*COLOR_W-1:0] correct_answer,
    input  logic [COLOR_W-1:0]          current_color,
    input  logic                        confirm_color,
    input  logic                        check_guess,
    input  logic                        BtnL,
    input  logic                        BtnR,
    input  logic                        new_game,
`ifdef MM_HISTORY_EN
    input  logic [GN_W-1:0]             hist_sel,
    output logic [NUM_PEGS*COLOR_W-1:0] hist_guess,
    output logic [CNT_W-1:0]            hist_exact,
    output logic [CNT_W-1:0]            hist_partial,
`endif
    output logic [IDX_W-1:0]            index,
    output logic [GN_W-1:0]             guess_num,
    output logic [NUM_PEGS*COLOR_W-1:0] current_guess,
    output logic [CNT_W-1:0]            exact_cnt,
    output logic [CNT_W-1:0]            partial_cnt,
    output logic                        score_valid,
    output logic                        q_Start,
    output logic                        q_Input,
    output logic                        q_Score,
    output logic                        q_Eval,
    output logic                        q_DoneC,
    output logic                        q_DoneNC
);
    localparam int NCOL   = (1 << COLOR_W) - 1;
    localparam int SC_LEN = NUM_PEGS + NCOL;
    localparam int SC_W   = $clog2(SC_LEN);

    typedef enum logic [2:0] {S_START, S_INPUT, S_SCORE, S_EVAL, S_DONEC, S_DONENC} state_t;
    state_t state_q, state_d;

    logic [NUM_PEGS-1:0][COLOR_W-1:0] guess_q, target_q;
    logic [IDX_W-1:0]                 idx_q;
    logic [GN_W-1:0]                  gn_q;
    logic [CNT_W-1:0]                 exact_q, partial_q, acc_q;
    logic [SC_W-1:0]                  sc_q;

    logic [COLOR_W-1:0]  colour;
    logic [NUM_PEGS-1:0] exact_v, g_hit, t_hit, filled_v;
    logic [CNT_W-1:0]    g_cnt, t_cnt, c_min;
    logic                phase_a, sc_last, exact_inc, all_set;

    // Phase B walks colours 1..NCOL as sc_q runs NUM_PEGS..SC_LEN-1.
    assign colour = COLOR_W'(sc_q - SC_W'(NUM_PEGS - 1));

    genvar g;
    generate
        for (g = 0; g < NUM_PEGS; g++) begin : g_lane
            mastermind_peg_lane #(.COLOR_W(COLOR_W)) u_lane (
                .guess  (guess_q[g]),
                .target (target_q[g]),
                .colour (colour),
                .exact  (exact_v[g]),
                .g_hit  (g_hit[g]),
                .t_hit  (t_hit[g]),
                .filled (filled_v[g])
            );
        end
    endgenerate

    function automatic logic [CNT_W-1:0] popc(input logic [NUM_PEGS-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_PEGS; i++) s = s + CNT_W'(v[i]);
        return s;
    endfunction

    assign g_cnt     = popc(g_hit);
    assign t_cnt     = popc(t_hit);
    assign c_min     = (g_cnt < t_cnt) ? g_cnt : t_cnt;
    assign phase_a   = (sc_q < SC_W'(NUM_PEGS));
    assign sc_last   = (sc_q == SC_W'(SC_LEN - 1));
    assign exact_inc = phase_a && exact_v[sc_q[IDX_W-1:0]];
    assign all_set   = &filled_v;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_START;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: state_d = S_INPUT;
            S_INPUT: if (check_guess && all_set) state_d = S_SCORE;
            S_SCORE: if (sc_last) state_d = S_EVAL;
            S_EVAL: begin
                if (exact_q == CNT_W'(NUM_PEGS))           state_d = S_DONEC;
                else if (gn_q == GN_W'(MAX_GUESSES - 1))   state_d = S_DONENC;
                else                                       state_d = S_INPUT;
            end
            default: state_d = state_q;
        endcase
        if (new_game) state_d = S_START;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            target_q  <= '0;
            guess_q   <= '0;
            idx_q     <= '0;
            gn_q      <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            acc_q     <= '0;
            sc_q      <= '0;
        end else begin
            case (state_q)
                S_START: begin
                    target_q  <= correct_answer;
                    guess_q   <= '0;
                    idx_q     <= '0;
                    gn_q      <= '0;
                    exact_q   <= '0;
                    partial_q <= '0;
                    acc_q     <= '0;
                    sc_q      <= '0;
                end
                S_INPUT: begin
                    // The write targets the cursor as it was before any same-cycle move.
                    if (confirm_color) guess_q[idx_q] <= current_color;
                    if (BtnR) begin
                        if (idx_q != IDX_W'(NUM_PEGS - 1)) idx_q <= idx_q + 1'b1;
                    end else if (BtnL && idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                    end
                    if (state_d == S_SCORE) begin
                        exact_q   <= '0;
                        partial_q <= '0;
                        acc_q     <= '0;
                        sc_q      <= '0;
                    end
                end
                S_SCORE: begin
                    sc_q <= sc_q + 1'b1;
                    if (phase_a) exact_q <= exact_q + CNT_W'(exact_inc);
                    else         acc_q   <= acc_q + c_min;
                    if (sc_last) partial_q <= acc_q + c_min - exact_q;
                end
                S_EVAL: if (state_d == S_INPUT) gn_q <= gn_q + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MM_HISTORY_EN
    logic [NUM_PEGS*COLOR_W-1:0] hist_g_q [MAX_GUESSES];
    logic [CNT_W-1:0]            hist_e_q [MAX_GUESSES];
    logic [CNT_W-1:0]            hist_p_q [MAX_GUESSES];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < MAX_GUESSES; i++) begin
                hist_g_q[i] <= '0;
                hist_e_q[i] <= '0;
                hist_p_q[i] <= '0;
            end
        end else if (state_q == S_START) begin
            for (int i = 0; i < MAX_GUESSES; i++) begin
                hist_g_q[i] <= '0;
                hist_e_q[i] <= '0;
                hist_p_q[i] <= '0;
            end
        end else if (state_q == S_EVAL) begin
            hist_g_q[gn_q] <= guess_q;
            hist_e_q[gn_q] <= exact_q;
            hist_p_q[gn_q] <= partial_q;
        end
    end

    always_comb begin
        hist_guess   = '0;
        hist_exact   = '0;
        hist_partial = '0;
        if (int'(hist_sel) < MAX_GUESSES) begin
            hist_guess   = hist_g_q[hist_sel];
            hist_exact   = hist_e_q[hist_sel];
            hist_partial = hist_p_q[hist_sel];
        end
    end
`endif

    assign index         = idx_q;
    assign guess_num     = gn_q;
    assign current_guess = guess_q;
    assign exact_cnt     = exact_q;
    assign partial_cnt   = partial_q;
    assign score_valid   = (state_q == S_EVAL);
    assign q_Start       = (state_q == S_START);
    assign q_Input       = (state_q == S_INPUT);
    assign q_Score       = (state_q == S_SCORE);
    assign q_Eval        = (state_q == S_EVAL);
    assign q_DoneC       = (state_q == S_DONEC);
    assign q_DoneNC      = (state_q == S_DONENC);
endmodule

// File: tb/tb_mastermind_core_param.sv
// Bench for mastermind_core_param: vector table of games plus hand-written corner sequences.
module tb_mastermind_core_param;
    localparam int N  = 4;
    localparam int CW = 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [N*CW-1:0] correct_answer = '0;
    logic [CW-1:0] current_color = '0;
    logic          confirm_color = 0, check_guess = 0, BtnL = 0, BtnR = 0, new_game = 0;
    logic [1:0]    index;
    logic [2:0]    guess_num;
    logic [N*CW-1:0] current_guess;
    logic [2:0]    exact_cnt, partial_cnt;
    logic          score_valid, q_Start, q_Input, q_Score, q_Eval, q_DoneC, q_DoneNC;
    logic [5:0]    st;
`ifdef MM_HISTORY_EN
    logic [2:0]    hist_sel = '0;
    logic [N*CW-1:0] hist_guess;
    logic [2:0]    hist_exact, hist_partial;
`endif

    mastermind_core_param dut (
        .Clk(Clk), .Reset(Reset), .correct_answer(correct_answer),
        .current_color(current_color), .confirm_color(confirm_color),
        .check_guess(check_guess), .BtnL(BtnL), .BtnR(BtnR), .new_game(new_game),
`ifdef MM_HISTORY_EN
        .hist_sel(hist_sel), .hist_guess(hist_guess),
        .hist_exact(hist_exact), .hist_partial(hist_partial),
`endif
        .index(index), .guess_num(guess_num), .current_guess(current_guess),
        .exact_cnt(exact_cnt), .partial_cnt(partial_cnt), .score_valid(score_valid),
        .q_Start(q_Start), .q_Input(q_Input), .q_Score(q_Score), .q_Eval(q_Eval),
        .q_DoneC(q_DoneC), .q_DoneNC(q_DoneNC)
    );

    always #5 Clk = ~Clk;
    assign st = {q_Start, q_Input, q_Score, q_Eval, q_DoneC, q_DoneNC};

    localparam logic [5:0] ST_START = 6'b100000, ST_INPUT = 6'b010000, ST_SCORE = 6'b001000,
                           ST_DONEC = 6'b000010, ST_DONENC = 6'b000001;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { logic [2:0] e; logic [2:0] p; } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [N*CW-1:0] tgt;
        logic [N*CW-1:0] gss;
        logic [2:0]      e;
        logic [2:0]      p;
        logic [5:0]      st_after;
        logic [2:0]      gn_after;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*CW-1:0] pk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Scoreboard: every score_valid pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (!Reset && score_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected score_valid", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("exact_cnt", 32'(exact_cnt), 32'(x.e));
                chk("partial_cnt", 32'(partial_cnt), 32'(x.p));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_game(input logic [N*CW-1:0] tgt);
        correct_answer = tgt;
        new_game = 1;
        tick();
        new_game = 0;
        tick();
    endtask

    task automatic enter_guess(input logic [N*CW-1:0] g);
        BtnL = 1;
        repeat (N - 1) tick();
        BtnL = 0;
        for (int k = 0; k < N; k++) begin
            current_color = g[k*CW +: CW];
            confirm_color = 1;
            BtnR = 1;
            tick();
        end
        confirm_color = 0;
        BtnR = 0;
        chk("guess buffer", 32'(current_guess), 32'(g));
    endtask

    task automatic submit(input logic [2:0] e, input logic [2:0] p);
        int n;
        exp_q.push_back('{e: e, p: p});
        check_guess = 1;
        tick();
        check_guess = 0;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!score_valid && n < 30);
        chk("score latency", 32'(n), 32'd12);
        tick();
    endtask

    initial begin
        vecs[0] = '{pk(1,2,3,4), pk(4,3,2,1), 3'd0, 3'd4, ST_INPUT, 3'd1};
        vecs[1] = '{pk(1,2,3,4), pk(1,1,2,2), 3'd1, 3'd1, ST_INPUT, 3'd1};
        vecs[2] = '{pk(1,2,3,4), pk(1,2,3,4), 3'd4, 3'd0, ST_DONEC, 3'd0};
        vecs[3] = '{pk(5,5,6,7), pk(5,6,5,5), 3'd1, 3'd2, ST_INPUT, 3'd1};
        vecs[4] = '{pk(7,7,7,7), pk(1,2,3,7), 3'd1, 3'd0, ST_INPUT, 3'd1};

        correct_answer = pk(1,2,3,4);
        repeat (3) tick();
        chk("reset state", 32'(st), 32'(ST_START));
        chk("reset index", 32'(index), 0);
        chk("reset guess_num", 32'(guess_num), 0);
        chk("reset guess", 32'(current_guess), 0);
        chk("reset counts", 32'({exact_cnt, partial_cnt}), 0);
        chk("reset score_valid", 32'(score_valid), 0);
        Reset = 0;
        tick();
        chk("start to input", 32'(st), 32'(ST_INPUT));

        for (int v = 0; v < 5; v++) begin
            start_game(vecs[v].tgt);
            enter_guess(vecs[v].gss);
            submit(vecs[v].e, vecs[v].p);
            chk("state after eval", 32'(st), 32'(vecs[v].st_after));
            chk("guess_num after eval", 32'(guess_num), 32'(vecs[v].gn_after));
            tick();
            chk("exact held", 32'(exact_cnt), 32'(vecs[v].e));
            chk("partial held", 32'(partial_cnt), 32'(vecs[v].p));
        end

        // Six misses lose the game; edits are then ignored.
        start_game(pk(1,2,3,4));
        for (int i = 0; i < 6; i++) begin
            enter_guess(pk(5,5,5,5));
            submit(3'd0, 3'd0);
            chk("loss guess_num", 32'(guess_num), (i < 5) ? 32'(i + 1) : 32'd5);
            chk("loss state", 32'(st), (i < 5) ? 32'(ST_INPUT) : 32'(ST_DONENC));
        end
        BtnL = 1; confirm_color = 1; current_color = 3'd1;
        tick();
        BtnL = 0; confirm_color = 0;
        BtnR = 1;
        tick();
        BtnR = 0;
        chk("donenc index held", 32'(index), 3);
        chk("donenc guess held", 32'(current_guess), 32'(pk(5,5,5,5)));
        chk("donenc stays", 32'(st), 32'(ST_DONENC));

        // Check with an empty peg is ignored.
        start_game(pk(1,2,3,4));
        enter_guess(pk(1,2,0,4));
        check_guess = 1;
        tick();
        check_guess = 0;
        chk("empty peg stays input", 32'(st), 32'(ST_INPUT));
        repeat (15) tick();
        chk("empty peg guess_num", 32'(guess_num), 0);

        // Cursor saturation and BtnR priority.
        start_game(pk(1,2,3,4));
        BtnL = 1; tick(); BtnL = 0;
        chk("cursor low saturate", 32'(index), 0);
        BtnR = 1; repeat (5) tick(); BtnR = 0;
        chk("cursor high saturate", 32'(index), 3);
        BtnL = 1; repeat (3) tick(); BtnL = 0;
        BtnR = 1; tick();
        BtnL = 1; tick();
        BtnL = 0; BtnR = 0;
        chk("btnL+btnR moves right", 32'(index), 2);

        // Asynchronous reset in the middle of scoring.
        start_game(pk(1,2,3,4));
        enter_guess(pk(1,2,3,4));
        check_guess = 1;
        tick();
        check_guess = 0;
        repeat (6) tick();
        chk("mid-score state", 32'(st), 32'(ST_SCORE));
        chk("mid-score exact", 32'(exact_cnt), 4);
        Reset = 1;
        #1;
        chk("abort state", 32'(st), 32'(ST_START));
        chk("abort outputs", 32'({index, guess_num, current_guess, exact_cnt, partial_cnt, score_valid}), 0);
        tick();
        Reset = 0;
        tick();
        chk("abort restart", 32'(st), 32'(ST_INPUT));

        // new_game out of DONEC.
        start_game(pk(2,4,6,1));
        enter_guess(pk(2,4,6,1));
        submit(3'd4, 3'd0);
        repeat (3) tick();
        chk("donec holds", 32'(st), 32'(ST_DONEC));
        new_game = 1; tick(); new_game = 0;
        chk("new_game to start", 32'(st), 32'(ST_START));
        tick();
        chk("new_game to input", 32'(st), 32'(ST_INPUT));
        chk("new_game clears", 32'({exact_cnt, guess_num, current_guess}), 0);

`ifdef MM_HISTORY_EN
        start_game(pk(1,2,3,4));
        enter_guess(pk(5,5,5,5));
        submit(3'd0, 3'd0);
        enter_guess(pk(1,2,4,3));
        submit(3'd2, 3'd2);
        hist_sel = 3'd1; #1;
        chk("hist1 guess", 32'(hist_guess), 32'(pk(1,2,4,3)));
        chk("hist1 counts", 32'({hist_exact, hist_partial}), 32'({3'd2, 3'd2}));
        hist_sel = 3'd0; #1;
        chk("hist0 guess", 32'(hist_guess), 32'(pk(5,5,5,5)));
        hist_sel = 3'd5; #1;
        chk("hist5 empty", 32'({hist_guess, hist_exact, hist_partial}), 0);
        hist_sel = 3'd7; #1;
        chk("hist7 out of range", 32'({hist_guess, hist_exact, hist_partial}), 0);
`endif

        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
